// File: rtl/crc_fcs_checker.sv
// Frame FCS checker: holds back the trailing four FCS bytes of each frame, feeds
// only payload bytes to the downstream slicing CRC stage, and reports the result.
module crc_fcs_checker #(
    parameter int DATA_BYTES = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*DATA_BYTES-1:0] in_data,
    input  logic [DATA_BYTES-1:0]   in_keep,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [8*DATA_BYTES-1:0] crc_data,
    output logic [DATA_BYTES-1:0]   crc_valid,
    output logic                    crc_reset,
    input  logic [31:0]             crc,
    output logic                    frame_done,
    output logic                    frame_ok,
    output logic                    frame_runt,
    output logic [15:0]             frame_len
);

    localparam int CW = $clog2(2*DATA_BYTES + 1);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_CHECK = 2'd3;

    logic [1:0]              r_state;
    logic [8*DATA_BYTES-1:0] r_hold;
    logic                    r_holdPresent;
    logic [8*DATA_BYTES-1:0] r_tail;
    logic [CW-1:0]           r_flushN;
    logic [31:0]             r_fcs;
    logic [15:0]             r_len;
    logic                    r_runt;

    int                       w_h;
    int                       w_n;
    int                       w_t;
    int                       w_p;
    int                       w_holdEmit;
    int                       w_flushN;
    int                       w_emitN;
    int                       w_lenBeatSum;
    int                       w_lenLastSum;
    logic [16*DATA_BYTES-1:0] w_comb;
    logic [31:0]              w_fcs;
    logic [15:0]              w_lenBeat;
    logic [15:0]              w_lenLast;
    logic [8*DATA_BYTES-1:0]  w_emitSrc;
    logic                     w_accept;

    // The combined stream is the held beat (when present) followed by the last
    // beat; its final four bytes are the FCS, everything before them is payload.
    always_comb begin
        w_h = r_holdPresent ? DATA_BYTES : 0;
        w_n = 0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (in_keep[i]) begin
                w_n = w_n + 1;
            end
        end
        w_t = w_h + w_n;
        w_p = w_t - 4;

        w_holdEmit = (w_p < w_h) ? w_p : w_h;
        if (w_holdEmit < 0) begin
            w_holdEmit = 0;
        end
        w_flushN = (w_p > w_h) ? (w_p - w_h) : 0;

        w_comb = r_holdPresent ? {in_data, r_hold} : {{(8*DATA_BYTES){1'b0}}, in_data};
        w_fcs  = '0;
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 2*DATA_BYTES; k++) begin
                if (k == w_p + j) begin
                    w_fcs[8*j +: 8] = w_comb[8*k +: 8];
                end
            end
        end

        w_lenBeatSum = int'(r_len) + DATA_BYTES;
        w_lenLastSum = int'(r_len) + w_n;
        w_lenBeat    = (w_lenBeatSum > 65535) ? 16'hFFFF : 16'(w_lenBeatSum);
        w_lenLast    = (w_lenLastSum > 65535) ? 16'hFFFF : 16'(w_lenLastSum);
    end

    always_comb begin
        in_ready   = !reset && ((r_state == S_EMPTY) || (r_state == S_HOLD));
        w_accept   = in_valid && in_ready;
        w_emitN    = 0;
        w_emitSrc  = r_hold;
        frame_done = 1'b0;
        frame_ok   = 1'b0;
        frame_runt = 1'b0;
        frame_len  = '0;
        crc_reset  = reset;

        if (!reset) begin
            case (r_state)
                S_EMPTY, S_HOLD: begin
                    if (w_accept) begin
                        w_emitN = in_last ? w_holdEmit : w_h;
                    end
                end
                S_FLUSH: begin
                    w_emitN   = int'(r_flushN);
                    w_emitSrc = r_tail;
                end
                S_CHECK: begin
                    frame_done = 1'b1;
                    frame_ok   = !r_runt && (crc == r_fcs);
                    frame_runt = r_runt;
                    frame_len  = r_len;
                    crc_reset  = 1'b1;
                end
                default: begin
                end
            endcase
        end

        crc_valid = '0;
        crc_data  = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (i < w_emitN) begin
                crc_valid[i]      = 1'b1;
                crc_data[8*i +: 8] = w_emitSrc[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_EMPTY;
            r_hold        <= '0;
            r_holdPresent <= 1'b0;
            r_tail        <= '0;
            r_flushN      <= '0;
            r_fcs         <= '0;
            r_len         <= '0;
            r_runt        <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY, S_HOLD: begin
                    if (w_accept) begin
                        if (!in_last) begin
                            r_hold        <= in_data;
                            r_holdPresent <= 1'b1;
                            r_len         <= w_lenBeat;
                            r_state       <= S_HOLD;
                        end else begin
                            r_tail   <= in_data;
                            r_flushN <= CW'(w_flushN);
                            r_fcs    <= w_fcs;
                            r_len    <= w_lenLast;
                            r_runt   <= (w_t < 5);
                            r_state  <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    r_len         <= '0;
                    r_holdPresent <= 1'b0;
                    r_runt        <= 1'b0;
                    r_state       <= S_EMPTY;
                end
                default: begin
                    r_state <= S_EMPTY;
                end
            endcase
        end
    end

endmodule
